// File: rtl/bcd_convert_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bcd_convert_scheduler
// Description : Four-requester round-robin scheduler feeding a sequential
//               6-bit binary to 2-digit BCD converter (shift-add-3).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_convert_scheduler #(
    parameter int MAX_VAL = 49
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [23:0] data_in,
    output logic [3:0]  ack,
    output logic        busy,
    output logic [3:0]  tens,
    output logic [3:0]  units,
    output logic [1:0]  src,
    output logic        valid
);

    localparam logic [5:0] c_max_val   = 6'(MAX_VAL);
    localparam logic [2:0] c_last_step = 3'd5;
    localparam logic [3:0] c_err_digit = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [1:0]  r_ptr;
    logic [2:0]  r_step;
    logic [5:0]  r_bin;
    logic [7:0]  r_bcd;
    logic        r_err;
    logic [1:0]  r_cur_src;
    logic [3:0]  r_ack;
    logic        r_valid;
    logic [3:0]  r_tens;
    logic [3:0]  r_units;
    logic [1:0]  r_src;

    logic        w_accept;
    logic        w_busy;
    logic [7:0]  w_req2;
    logic [3:0]  w_rot;
    logic [1:0]  w_off;
    logic [1:0]  w_gnt;
    logic [5:0]  w_operand;
    logic [3:0]  w_units_adj;
    logic [3:0]  w_tens_adj;
    logic [7:0]  w_bcd_nxt;
    logic [5:0]  w_bin_nxt;

    // Rotate requests so bit 0 is the current round-robin head.
    assign w_req2 = {req, req} >> r_ptr;
    assign w_rot  = w_req2[3:0];

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
    end

    assign w_gnt = r_ptr + w_off;

    always_comb begin
        w_operand = data_in[5:0];
        case (w_gnt)
            2'd0:    w_operand = data_in[5:0];
            2'd1:    w_operand = data_in[11:6];
            2'd2:    w_operand = data_in[17:12];
            default: w_operand = data_in[23:18];
        endcase
    end

    // One double-dabble step: correct nibbles >= 5, then shift the operand MSB in.
    assign w_units_adj = (r_bcd[3:0] >= 4'd5) ? (r_bcd[3:0] + 4'd3) : r_bcd[3:0];
    assign w_tens_adj  = (r_bcd[7:4] >= 4'd5) ? (r_bcd[7:4] + 4'd3) : r_bcd[7:4];
    assign w_bcd_nxt   = {w_tens_adj[2:0], w_units_adj, r_bin[5]};
    assign w_bin_nxt   = {r_bin[4:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                w_busy = 1'b1;
                if (r_step == c_last_step) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_busy = 1'b1;
                if (|req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CONV;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= 2'd0;
            r_step    <= 3'd0;
            r_bin     <= 6'd0;
            r_bcd     <= 8'd0;
            r_err     <= 1'b0;
            r_cur_src <= 2'd0;
            r_ack     <= 4'd0;
            r_valid   <= 1'b0;
            r_tens    <= 4'd0;
            r_units   <= 4'd0;
            r_src     <= 2'd0;
        end else begin
            r_ack   <= 4'd0;
            r_valid <= 1'b0;
            if (w_accept) begin
                r_ack     <= 4'b0001 << w_gnt;
                r_ptr     <= w_gnt + 2'd1;
                r_bin     <= w_operand;
                r_bcd     <= 8'd0;
                r_step    <= 3'd0;
                r_err     <= (w_operand > c_max_val);
                r_cur_src <= w_gnt;
            end else if (r_state == CONV) begin
                r_bin <= w_bin_nxt;
                r_bcd <= w_bcd_nxt;
                if (r_step == c_last_step) begin
                    r_step  <= 3'd0;
                    r_valid <= 1'b1;
                    r_src   <= r_cur_src;
                    r_tens  <= r_err ? c_err_digit : w_bcd_nxt[7:4];
                    r_units <= r_err ? c_err_digit : w_bcd_nxt[3:0];
                end else begin
                    r_step <= r_step + 3'd1;
                end
            end
        end
    end

    assign ack   = r_ack;
    assign busy  = w_busy;
    assign valid = r_valid;
    assign tens  = r_tens;
    assign units = r_units;
    assign src   = r_src;

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_convert_scheduler
// Description : Scoreboard bench for bcd_convert_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_convert_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [23:0] data_in;
    logic [3:0]  ack;
    logic        busy;
    logic [3:0]  tens;
    logic [3:0]  units;
    logic [1:0]  src;
    logic        valid;

    typedef struct {
        int s;
        int t;
        int u;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    bcd_convert_scheduler #(.MAX_VAL(49)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data_in (data_in),
        .ack     (ack),
        .busy    (busy),
        .tens    (tens),
        .units   (units),
        .src     (src),
        .valid   (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: every valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (q.size() == 0) begin
                timeout("unexpected_valid");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_src", int'(src), e.s);
                chk("sb_tens", int'(tens), e.t);
                chk("sb_units", int'(units), e.u);
            end
        end
    end

    task automatic push(input int s, input int t, input int u);
        exp_t e;
        e.s = s; e.t = t; e.u = u;
        q.push_back(e);
    endtask

    task automatic wait_ack(output logic [3:0] a, output int at);
        a  = 4'd0;
        at = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack != 4'd0) begin
                a  = ack;
                at = cyc;
                return;
            end
        end
        timeout("ack_wait");
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) return;
            @(negedge clk);
        end
        timeout("drain");
    endtask

    task automatic set_op(input int idx, input logic [5:0] op);
        data_in[idx*6 +: 6] = op;
    endtask

    // Single request, latency and ack-width checks; req dropped once acked.
    task automatic run_one(input int idx, input logic [5:0] op, input int t, input int u);
        logic [3:0] a;
        int         at;
        @(negedge clk);
        set_op(idx, op);
        req = 4'b0001 << idx;
        push(idx, t, u);
        wait_ack(a, at);
        req = 4'd0;
        chk("ack_onehot", int'(a), 1 << idx);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) chk("ack_one_cycle", int'(ack), 0);
            if (i == 3) chk("busy_conv", int'(busy), 1);
        end
        chk("latency_valid", int'(valid), 1);
        drain();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", int'(valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] a;
        logic [3:0] prev_a;
        int         at;
        int         prev_at;
        logic [3:0] exp_a [4];

        rst_n   = 1'b0;
        req     = 4'd0;
        data_in = 24'd0;
        #1;
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_tens_units_src", int'({tens, units, src}), 0);
        // Requests during reset must not be acknowledged.
        req = 4'b1111;
        repeat (3) @(negedge clk);
        chk("no_ack_in_reset", int'(ack), 0);
        req   = 4'd0;
        rst_n = 1'b1;

        // Single request, then boundary operands.
        run_one(1, 6'd37, 3, 7);
        chk("hold_tens", int'(tens), 3);
        chk("hold_src", int'(src), 1);
        run_one(0, 6'd0, 0, 0);
        run_one(0, 6'd49, 4, 9);
        run_one(0, 6'd50, 10, 10);
        run_one(0, 6'd63, 10, 10);

        // Simultaneous requests from ptr 0.
        do_reset();
        @(negedge clk);
        set_op(0, 6'd0); set_op(1, 6'd9); set_op(2, 6'd10); set_op(3, 6'd49);
        push(0, 0, 0); push(1, 0, 9); push(2, 1, 0); push(3, 4, 9);
        req     = 4'b1111;
        prev_at = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(a, at);
            if (k == 3) req = 4'd0;
            chk("rr_order", int'(a), 1 << k);
            if (k > 0) chk("rr_spacing", at - prev_at, 7);
            prev_at = at;
            repeat (6) @(negedge clk);
            chk("rr_valid", int'(valid), 1);
        end
        drain();

        // Fairness with req0 and req2 held.
        @(negedge clk);
        set_op(0, 6'd12); set_op(2, 6'd21);
        exp_a[0] = 4'b0001; exp_a[1] = 4'b0100; exp_a[2] = 4'b0001; exp_a[3] = 4'b0100;
        push(0, 1, 2); push(2, 2, 1); push(0, 1, 2); push(2, 2, 1);
        req    = 4'b0101;
        prev_a = 4'd0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(a, at);
            if (k == 3) req = 4'd0;
            chk("fair_grant", int'(a), int'(exp_a[k]));
            if (k > 0) chk("fair_no_repeat", int'(a != prev_a), 1);
            prev_a = a;
        end
        drain();

        // Reset at conversion step 3.
        @(negedge clk);
        set_op(0, 6'd30);
        req = 4'b0001;
        wait_ack(a, at);
        req = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_outputs", int'({tens, units, src}), 0);
        chk("midrst_ack", int'(ack), 0);
        repeat (8) begin
            @(negedge clk);
            if (valid) chk("midrst_no_valid", int'(valid), 0);
        end
        chk("midrst_valid", int'(valid), 0);
        rst_n = 1'b1;
        run_one(0, 6'd25, 2, 5);

        // Operand changed after capture.
        @(negedge clk);
        set_op(2, 6'd44);
        req = 4'b0100;
        push(2, 4, 4);
        wait_ack(a, at);
        req = 4'd0;
        chk("late_ack", int'(a), 4);
        @(negedge clk);
        set_op(2, 6'd13);
        drain();
        chk("late_hold_units", int'(units), 4);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
